// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM-backed data-memory responder.
// Used by sram_mem_responder (optional SRAM_READ_BUFFER_EN) and sram_wait_counter.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_WAIT_CYCLES = 4;
    localparam int DEF_SRAM_AW     = 18;
    // Wide enough for WAIT_CYCLES+1 (the write high-phase address guard).
    localparam int CNT_W           = 5;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: reloads on phase entry, counts while enabled.
// Latency: last is a combinational decode of the registered count (count==1).
// Backpressure: none; the owning FSM decides when to load and enable.
module sram_wait_counter
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: 32-bit word as two 16-bit async-SRAM accesses.
// Latency: read 2*WAIT_CYCLES+1, write 2*WAIT_CYCLES+2 (buffer hit: 1 with SRAM_READ_BUFFER_EN).
// Backpressure: ready drops while a request is in flight; requester holds inputs until ready=1.
module sram_mem_responder
    import sram_ctrl_pkg::*;
#(
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        Address,
    input  logic [31:0]        ST_val,
    output logic [31:0]        MEM_read_value,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;

    state_t           state;
    op_t              op;
    logic [WW-1:0]    word_q;
    logic [15:0]      st_hi_q;
    logic [WW-1:0]    word_in;
    logic             req;
    logic             hit;
    logic [31:0]      hit_dat;
    logic             cnt_last;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;

    // Below-base addresses wrap modulo the SRAM word space.
    assign word_in = WW'((Address - 32'(BASE_ADDR)) >> 2);
    assign req     = MEM_R_EN | MEM_W_EN;
    assign ready   = (state == IDLE && !req) || (state == DONE);

    assign cnt_load = (state == IDLE && req && !hit) || (state == LO && cnt_last);
    // High write phase spends one extra cycle with we_n high while the address settles.
    assign cnt_val  = (state == LO && op == OP_WR) ? CNT_W'(WAIT_CYCLES + 1) : CNT_W'(WAIT_CYCLES);

    sram_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (state == LO || state == HI),
        .last     (cnt_last)
    );

`ifdef SRAM_READ_BUFFER_EN
    logic          buf_vld;
    logic [WW-1:0] buf_tag;
    logic [31:0]   buf_dat;

    assign hit     = MEM_R_EN && !MEM_W_EN && buf_vld && (buf_tag == word_in);
    assign hit_dat = buf_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_tag <= '0;
            buf_dat <= '0;
        end else if (state == IDLE && MEM_W_EN && buf_vld && buf_tag == word_in) begin
            buf_dat <= ST_val;
        end else if (state == HI && cnt_last && op == OP_RD) begin
            buf_vld <= 1'b1;
            buf_tag <= word_q;
            buf_dat <= {sram_rdata, MEM_read_value[15:0]};
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_dat = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op             <= OP_RD;
            word_q         <= '0;
            st_hi_q        <= '0;
            MEM_read_value <= '0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            sram_we_n      <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op      <= MEM_W_EN ? OP_WR : OP_RD;
                    word_q  <= word_in;
                    st_hi_q <= ST_val[31:16];
                    if (hit) begin
                        state          <= DONE;
                        MEM_read_value <= hit_dat;
                    end else begin
                        state      <= LO;
                        sram_addr  <= {word_in, 1'b0};
                        sram_wdata <= ST_val[15:0];
                        sram_we_n  <= !MEM_W_EN;
                    end
                end
                LO: if (cnt_last) begin
                    state      <= HI;
                    sram_addr  <= {word_q, 1'b1};
                    sram_wdata <= st_hi_q;
                    sram_we_n  <= 1'b1;
                    if (op == OP_RD) MEM_read_value[15:0] <= sram_rdata;
                end
                HI: if (cnt_last) begin
                    state     <= DONE;
                    sram_we_n <= 1'b1;
                    if (op == OP_RD) MEM_read_value[31:16] <= sram_rdata;
                end else if (op == OP_WR) begin
                    sram_we_n <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with a behavioural 16-bit SRAM (low 8 address bits decoded).
module tb_sram_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] ST_val = '0;
    logic [31:0] MEM_read_value;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [256];
    int wr_lo2 = 0, wr_hi3 = 0, wr_total = 0;

    sram_mem_responder #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .Address        (Address),
        .ST_val         (ST_val),
        .MEM_read_value (MEM_read_value),
        .ready          (ready),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .sram_we_n      (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_rdata = mem[sram_addr[7:0]];

    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;

    always @(negedge clk) begin
        if (!sram_we_n) begin
            wr_total = wr_total + 1;
            if (sram_addr == 18'd2 && sram_wdata == 16'hBEEF) wr_lo2 = wr_lo2 + 1;
            if (sram_addr == 18'd3 && sram_wdata == 16'hDEAD) wr_hi3 = wr_hi3 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Raise a request, count rising edges until ready=1, then release after the consuming edge.
    task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [17:0] a_lo, output logic [17:0] a_hi);
        @(posedge clk); #1;
        MEM_R_EN = r; MEM_W_EN = w; Address = a; ST_val = d;
        lat = 0; a_lo = 'x; a_hi = 'x;
        while (lat < 100) begin
            @(negedge clk);
            if (lat == 1) a_lo = sram_addr;
            if (lat == 5) a_hi = sram_addr;
            if (ready) break;
            @(posedge clk);
            lat++;
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    initial begin
        int lat;
        logic [17:0] alo, ahi, prev;
        int t0, l0, h0;

        for (int i = 0; i < 256; i++) mem[i] = '0;

        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_wdata", {16'd0, sram_wdata}, 32'd0);
        check("rst_rdval", MEM_read_value, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Write 1028 = DEADBEEF
        t0 = wr_total; l0 = wr_lo2; h0 = wr_hi3;
        do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat, alo, ahi);
        check("wr_latency", lat, 32'd10);
        check("wr_lo_cycles", wr_lo2 - l0, 32'd4);
        check("wr_hi_cycles", wr_hi3 - h0, 32'd4);
        check("wr_total_strobes", wr_total - t0, 32'd8);
        check("wr_lo_addr", {14'd0, alo}, 32'd2);
        check("wr_hi_addr", {14'd0, ahi}, 32'd3);

        // Read back 1028
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat, alo, ahi);
        check("rd_latency", lat, 32'd9);
        check("rd_value", MEM_read_value, 32'hDEADBEEF);
        check("rd_lo_addr", {14'd0, alo}, 32'd2);

        // Idle for 20 cycles
        prev = sram_addr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, ready}, 32'd1);
            check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
            check("idle_addr", {14'd0, sram_addr}, {14'd0, prev});
        end

        // Both enables: write wins, read value untouched
        do_req(1'b1, 1'b1, 32'd1024, 32'h12345678, lat, alo, ahi);
        check("both_latency", lat, 32'd10);
        check("both_rdval_held", MEM_read_value, 32'hDEADBEEF);
        check("both_mem_lo", {16'd0, mem[0]}, 32'h5678);
        check("both_mem_hi", {16'd0, mem[1]}, 32'h1234);

        // Below-base address wraps: (0-1024)>>2 mod 2^17 = 0x1FF00
        do_req(1'b1, 1'b0, 32'd0, 32'h0, lat, alo, ahi);
        check("wrap_lo_addr", {14'd0, alo}, 32'h3FE00);
        check("wrap_hi_addr", {14'd0, ahi}, 32'h3FE01);
        check("wrap_latency", lat, 32'd9);
        check("wrap_value", MEM_read_value, 32'h12345678);

        // Reset in the low phase of a write
        @(posedge clk); #1;
        MEM_W_EN = 1'b1; Address = 32'd1024; ST_val = 32'hAAAABBBB;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b0; MEM_W_EN = 1'b0;
        #1;
        check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
        check("mid_rst_wdata", {16'd0, sram_wdata}, 32'd0);
        check("mid_rst_rdval", MEM_read_value, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk); rst = 1'b1;
        do_req(1'b1, 1'b0, 32'd1024, 32'h0, lat, alo, ahi);
        check("post_rst_latency", lat, 32'd9);
        check("post_rst_value", MEM_read_value, 32'h1234BBBB);

`ifdef SRAM_READ_BUFFER_EN
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat, alo, ahi);
        check("buf_fill_latency", lat, 32'd9);
        prev = sram_addr;
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat, alo, ahi);
        check("buf_hit_latency", lat, 32'd1);
        check("buf_hit_addr", {14'd0, alo}, {14'd0, prev});
        check("buf_hit_value", MEM_read_value, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'd1028, 32'h1, lat, alo, ahi);
        check("buf_wr_latency", lat, 32'd10);
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, lat, alo, ahi);
        check("buf_upd_latency", lat, 32'd1);
        check("buf_upd_value", MEM_read_value, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
